// File: rtl/jk_excitation_sequencer_pkg.sv
// jk_seq_pkg: FSM state type and per-bit minimal-toggle JK excitation shared by the sequencer.
package jk_seq_pkg;
    typedef enum logic {INIT, RUN} seq_state_e;
    function automatic logic [1:0] jk_excite(input logic q, input logic n);
        return {~q & n, q & ~n};
    endfunction
endpackage

// File: rtl/jk_excitation_sequencer_if.sv
// jk_excitation_sequencer_if: control, load handshake, excitation and feedback signals of the sequencer.
interface jk_excitation_sequencer_if #(parameter int WIDTH = 4);
    logic en, up, load_valid, load_ready, wrap, load_err, fb_err;
    logic [WIDTH-1:0] load_value, j, k, state_q, fb_q;
    modport master (
        output en, up, load_valid, load_value, fb_q,
        input  load_ready, j, k, state_q, wrap, load_err, fb_err
    );
    modport slave (
        input  en, up, load_valid, load_value, fb_q,
        output load_ready, j, k, state_q, wrap, load_err, fb_err
    );
endinterface

// File: rtl/jk_excitation_sequencer_excite_bank.sv
// jk_excite_bank: combinational (q, next) -> (j, k) mapping for a WIDTH-bit JK bank.
module jk_excite_bank import jk_seq_pkg::*; #(parameter int WIDTH = 4) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_next,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign {o_j[i], o_k[i]} = jk_excite(i_q[i], i_next[i]);
    end
endmodule

// File: rtl/jk_excitation_sequencer.sv
// jk_excitation_sequencer: drives J/K of an external JK bank through a modulo-MOD up/down count; `JK_FB_CHECK_EN adds a feedback checker.
module jk_excitation_sequencer import jk_seq_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input logic clk,
    input logic rst_n,
    jk_excitation_sequencer_if.slave bus
);
    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MOD - 1);
    seq_state_e       r_fsm;
    logic [WIDTH-1:0] r_state_q, w_next, w_j, w_k;
    logic             r_wrap, r_load_err, r_fb_err, r_fb_arm, r_load_ready;
    logic             w_run, w_load, w_in_range, w_step, w_wrap;
    assign w_run      = r_fsm == RUN;
    assign w_load     = w_run & bus.load_valid;
    assign w_in_range = {1'b0, bus.load_value} < (WIDTH+1)'(MOD);
    assign w_step     = w_run & ~w_load & bus.en;
    assign w_wrap     = w_step & (bus.up ? r_state_q == LP_MAX : r_state_q == '0);
    always_comb begin
        w_next = !w_run  ? '0 :
                 w_load  ? (w_in_range ? bus.load_value : '0) :
                 !w_step ? r_state_q :
                 bus.up  ? (r_state_q == LP_MAX ? '0 : r_state_q + WIDTH'(1)) :
                           (r_state_q == '0 ? LP_MAX : r_state_q - WIDTH'(1));
    end
    jk_excite_bank #(.WIDTH(WIDTH)) u_bank (
        .i_q    (r_state_q),
        .i_next (w_next),
        .o_j    (w_j),
        .o_k    (w_k)
    );
    // INIT drives K everywhere so the reset-less bank is cleared regardless of its power-up value
    assign bus.j          = w_run ? w_j : '0;
    assign bus.k          = w_run ? w_k : '1;
    assign bus.state_q    = r_state_q;
    assign bus.wrap       = r_wrap;
    assign bus.load_err   = r_load_err;
    assign bus.load_ready = r_load_ready;
    assign bus.fb_err     = r_fb_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm        <= INIT;
            r_state_q    <= '0;
            r_wrap       <= 1'b0;
            r_load_err   <= 1'b0;
            r_load_ready <= 1'b0;
            r_fb_arm     <= 1'b0;
            r_fb_err     <= 1'b0;
        end else begin
            r_fsm        <= RUN;
            r_state_q    <= w_next;
            r_wrap       <= w_wrap;
            r_load_err   <= w_load & ~w_in_range;
            r_load_ready <= 1'b1;
            r_fb_arm     <= w_run;
`ifdef JK_FB_CHECK_EN
            r_fb_err     <= r_fb_err | (r_fb_arm & (bus.fb_q != r_state_q));
`else
            r_fb_err     <= 1'b0;
`endif
        end
    end
`ifndef JK_FB_CHECK_EN
    logic w_unused_fb;
    assign w_unused_fb = ^{bus.fb_q, r_fb_arm};
`endif
endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// tb_jk_excitation_sequencer: table-driven scoreboard bench with an ideal reset-less JK bank model in the feedback path.
module tb_jk_excitation_sequencer;
    typedef struct {
        logic       en, up, lv;
        logic [3:0] lval, e_state;
        logic       e_wrap, e_err, chk_jk;
        logic [3:0] e_j, e_k;
    } vec_t;
    typedef struct {
        logic [3:0] st;
        logic       wr, er;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bank = 4'b1011;
    logic       corrupt = 1'b0;
    int         n_chk = 0, n_fail = 0;
    vec_t       tbl[22];
    exp_t       sbq[$];
    jk_excitation_sequencer_if #(.WIDTH(4)) bus ();
    jk_excitation_sequencer #(.WIDTH(4), .MOD(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.fb_q = bank ^ {3'b000, corrupt};
    initial begin
        #20;
        forever #5 clk = ~clk;
    end
    always @(posedge clk)
        for (int b = 0; b < 4; b++)
            bank[b] <= bus.j[b] & bus.k[b] ? ~bank[b] : bus.j[b] ? 1'b1 : bus.k[b] ? 1'b0 : bank[b];
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic vec_t mk(input logic en, input logic up, input logic lv, input logic [3:0] lval,
                                input logic [3:0] st, input logic wr, input logic er,
                                input logic cj, input logic [3:0] ej, input logic [3:0] ek);
        vec_t v;
        v.en = en; v.up = up; v.lv = lv; v.lval = lval; v.e_state = st;
        v.e_wrap = wr; v.e_err = er; v.chk_jk = cj; v.e_j = ej; v.e_k = ek;
        return v;
    endfunction
    task automatic step(input vec_t v);
        exp_t e;
        bus.en = v.en; bus.up = v.up; bus.load_valid = v.lv; bus.load_value = v.lval;
        #1;
        if (v.chk_jk) begin
            chk("j", 32'(bus.j), 32'(v.e_j));
            chk("k", 32'(bus.k), 32'(v.e_k));
        end
        chk("no_j_and_k", 32'(bus.j & bus.k), 0);
        sbq.push_back('{v.e_state, v.e_wrap, v.e_err});
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sbq.pop_front();
            chk("state_q", 32'(bus.state_q), 32'(e.st));
            chk("bank_q", 32'(bank), 32'(e.st));
            chk("wrap", 32'(bus.wrap), 32'(e.wr));
            chk("load_err", 32'(bus.load_err), 32'(e.er));
        end
    endtask
    initial begin
        for (int i = 0; i < 12; i++)
            tbl[i] = mk(1, 1, 0, 0, 4'((i + 1) % 10), i == 9, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 1, 4'd0,  4'd0, 0, 0, 1, 4'b0000, 4'b0010);
        tbl[13] = mk(1, 0, 0, 4'd0,  4'd9, 1, 0, 1, 4'b1001, 4'b0000);
        tbl[14] = mk(1, 1, 1, 4'd7,  4'd7, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 1, 4'd12, 4'd0, 0, 1, 1, 4'b0000, 4'b0111);
        tbl[16] = mk(0, 1, 0, 4'd0,  4'd0, 0, 0, 1, 4'b0000, 4'b0000);
        tbl[17] = mk(1, 0, 0, 4'd0,  4'd9, 1, 0, 0, 0, 0);
        tbl[18] = mk(1, 1, 0, 4'd0,  4'd0, 1, 0, 0, 0, 0);
        tbl[19] = mk(1, 1, 1, 4'd9,  4'd9, 0, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 1, 4'd10, 4'd0, 0, 1, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 4'd0,  4'd0, 0, 0, 0, 0, 0);
        bus.en = 0; bus.up = 0; bus.load_valid = 0; bus.load_value = 0;
        #2;
        chk("rst_state_q", 32'(bus.state_q), 0);
        chk("rst_load_ready", 32'(bus.load_ready), 0);
        chk("rst_wrap", 32'(bus.wrap), 0);
        chk("rst_load_err", 32'(bus.load_err), 0);
        chk("rst_fb_err", 32'(bus.fb_err), 0);
        #3 rst_n = 1'b1;
        #1;
        chk("init_j", 32'(bus.j), 0);
        chk("init_k", 32'(bus.k), 32'hF);
        chk("init_bank_preset", 32'(bank), 32'hB);
        bus.en = 1; bus.up = 1; bus.load_valid = 1; bus.load_value = 4'd5;
        @(posedge clk);
        #1;
        chk("init_bank_cleared", 32'(bank), 0);
        chk("init_state_ignores_req", 32'(bus.state_q), 0);
        chk("run_load_ready", 32'(bus.load_ready), 1);
        for (int i = 0; i < 22; i++) step(tbl[i]);
        chk("fb_err_clean_run", 32'(bus.fb_err), 0);
        step(mk(0, 1, 1, 4'd5, 4'd5, 0, 0, 0, 0, 0));
        step(mk(1, 1, 0, 4'd0, 4'd6, 0, 0, 0, 0, 0));
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_state_q", 32'(bus.state_q), 0);
        chk("async_rst_load_ready", 32'(bus.load_ready), 0);
        chk("async_rst_k", 32'(bus.k), 32'hF);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("reinit_j", 32'(bus.j), 0);
        chk("reinit_k", 32'(bus.k), 32'hF);
        @(posedge clk);
        #1;
        chk("reinit_bank", 32'(bank), 0);
        chk("reinit_load_ready", 32'(bus.load_ready), 1);
        step(mk(1, 1, 0, 4'd0, 4'd1, 0, 0, 0, 0, 0));
        step(mk(0, 1, 1, 4'd3, 4'd3, 0, 0, 0, 0, 0));
        corrupt = 1'b1;
        step(mk(0, 1, 0, 4'd0, 4'd3, 0, 0, 0, 0, 0));
        corrupt = 1'b0;
`ifdef JK_FB_CHECK_EN
        chk("fb_err_set", 32'(bus.fb_err), 1);
        step(mk(1, 1, 0, 4'd0, 4'd4, 0, 0, 0, 0, 0));
        chk("fb_err_sticky", 32'(bus.fb_err), 1);
`else
        chk("fb_err_tied_low", 32'(bus.fb_err), 0);
        step(mk(1, 1, 0, 4'd0, 4'd4, 0, 0, 0, 0, 0));
        chk("fb_err_still_low", 32'(bus.fb_err), 0);
`endif
        rst_n = 1'b0;
        #1;
        chk("fb_err_cleared_by_rst", 32'(bus.fb_err), 0);
        chk("scoreboard_drained", 32'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
